// File: rtl/ld_sd_mem_resp_pkg.sv
// Shared types and constants for the load/store memory responder.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsu_state_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_SD = 1'b1
    } lsu_op_t;

    localparam logic [3:0] LSU_BE_WORD = 4'hF;

endpackage

// File: rtl/ld_sd_mem_resp_if.sv
// Data-memory req/gnt/rvalid bus between the responder and the memory.
interface ld_sd_mem_resp_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_be;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/ld_sd_mem_resp_watchdog.sv
// Cycle counter that flags when an access has waited TIMEOUT_CYCLES cycles in one state.
module lsu_watchdog
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    // Count only has to reach TIMEOUT_CYCLES-1; expiry is judged on the last counted cycle.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ld_sd_mem_resp.sv
// Memory-side responder: issues one word access per accepted load/store and
// returns load data with its destination register for writeback.
module ld_sd_mem_resp
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      lsu_clk,
    input  logic                      lsu_rst,
    input  logic [DATA_WIDTH-1:0]     addr,
    input  logic                      ld_valid,
    input  logic                      sd_valid,
    input  logic [DATA_WIDTH-1:0]     st_data,
    input  logic [GPR_ADDR_WIDTH-1:0] ld_rd,
    ld_sd_mem_resp_if.master          dmem,
    output logic [DATA_WIDTH-1:0]     ld_data,
    output logic [GPR_ADDR_WIDTH-1:0] ld_rd_o,
    output logic                      ld_wb_en,
    output logic                      lsu_busy,
    output logic                      lsu_err
);
    lsu_state_t                state_q, state_d;
    lsu_op_t                   op_q, op_d;
    logic [DATA_WIDTH-1:2]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [GPR_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     ld_data_q, ld_data_d;
    logic [GPR_ADDR_WIDTH-1:0] ld_rd_o_q, ld_rd_o_d;
    logic                      wb_q, wb_d;
    logic                      err_q, err_d;
    logic                      err_pend_q, err_pend_d;
    logic                      err_event;
    logic                      wd_expired;

    lsu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (lsu_clk),
        .rst_n   (lsu_rst),
        .clr     (state_d != state_q),
        .en      (state_q != IDLE),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        ld_data_d = ld_data_q;
        ld_rd_o_d = ld_rd_o_q;
        wb_d      = 1'b0;
        err_event = 1'b0;

        case (state_q)
            IDLE: begin
                if ((ld_valid ^ sd_valid) && (addr[1:0] == 2'b00)) begin
                    op_d    = ld_valid ? OP_LD : OP_SD;
                    addr_d  = addr[DATA_WIDTH-1:2];
                    wdata_d = st_data;
                    rd_d    = ld_rd;
                    state_d = REQ;
                end else if (ld_valid || sd_valid) begin
                    err_event = 1'b1;
                end
            end
            REQ: begin
                // A new request while busy is dropped; the in-flight access is untouched.
                if (ld_valid || sd_valid) err_event = 1'b1;
                if (dmem.dmem_gnt) begin
                    state_d = (op_q == OP_SD) ? IDLE : WAIT_R;
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    err_event = 1'b1;
                end
            end
            WAIT_R: begin
                if (ld_valid || sd_valid) err_event = 1'b1;
                if (dmem.dmem_rvalid) begin
                    ld_data_d = dmem.dmem_rdata;
                    ld_rd_o_d = rd_q;
                    wb_d      = 1'b1;
                    state_d   = IDLE;
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    err_event = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An error that coincides with a writeback is reported one cycle later.
        err_d      = (err_event || err_pend_q) && !wb_d;
        err_pend_d = (err_event || err_pend_q) && wb_d;
    end

    always_ff @(posedge lsu_clk or negedge lsu_rst) begin
        if (!lsu_rst) begin
            state_q    <= IDLE;
            op_q       <= OP_LD;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            ld_data_q  <= '0;
            ld_rd_o_q  <= '0;
            wb_q       <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            ld_data_q  <= ld_data_d;
            ld_rd_o_q  <= ld_rd_o_d;
            wb_q       <= wb_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = (state_q == REQ) && (op_q == OP_SD);
    assign dmem.dmem_addr  = {addr_q, 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = (state_q == REQ) ? LSU_BE_WORD : 4'h0;

    assign ld_data  = ld_data_q;
    assign ld_rd_o  = ld_rd_o_q;
    assign ld_wb_en = wb_q;
    assign lsu_err  = err_q;
    assign lsu_busy = (state_q != IDLE);
endmodule

// File: tb/tb_ld_sd_mem_resp.sv
// Directed self-checking bench for ld_sd_mem_resp with an 8-cycle watchdog.
module tb_ld_sd_mem_resp;
    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        ld_valid;
    logic        sd_valid;
    logic [31:0] st_data;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd_o;
    logic        ld_wb_en;
    logic        lsu_busy;
    logic        lsu_err;

    int errors = 0;
    int checks = 0;

    ld_sd_mem_resp_if #(.DATA_WIDTH(32)) dmem_bus ();

    ld_sd_mem_resp #(
        .DATA_WIDTH     (32),
        .GPR_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .lsu_clk  (clk),
        .lsu_rst  (rst_n),
        .addr     (addr),
        .ld_valid (ld_valid),
        .sd_valid (sd_valid),
        .st_data  (st_data),
        .ld_rd    (ld_rd),
        .dmem     (dmem_bus.master),
        .ld_data  (ld_data),
        .ld_rd_o  (ld_rd_o),
        .ld_wb_en (ld_wb_en),
        .lsu_busy (lsu_busy),
        .lsu_err  (lsu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; addr = '0; ld_valid = 0; sd_valid = 0; st_data = '0; ld_rd = '0;
        dmem_bus.dmem_gnt = 0; dmem_bus.dmem_rvalid = 0; dmem_bus.dmem_rdata = '0;
        #12;
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, lsu_busy, ld_wb_en, lsu_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: req/we/busy/wb/err=%b required 00000",
                {dmem_bus.dmem_req, dmem_bus.dmem_we, lsu_busy, ld_wb_en, lsu_err});
        end
        checks++;
        if (ld_data !== 32'h0 || ld_rd_o !== 5'h0 || dmem_bus.dmem_addr !== 32'h0 || dmem_bus.dmem_be !== 4'h0) begin
            errors++; $display("FAIL reset_data: ld_data=%h rd=%0d addr=%h be=%h required all 0",
                ld_data, ld_rd_o, dmem_bus.dmem_addr, dmem_bus.dmem_be);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        checks++;
        if (lsu_busy !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b req=%b required 0 0", lsu_busy, dmem_bus.dmem_req);
        end
        $display("test_reset done");
    endtask

    task automatic test_load();
        int busy_cnt = 0;
        addr = 32'h100; ld_rd = 5'd5; ld_valid = 1;
        tick(); ld_valid = 0;
        if (lsu_busy) busy_cnt++;
        checks++;
        if (dmem_bus.dmem_req !== 1 || dmem_bus.dmem_we !== 0 || dmem_bus.dmem_addr !== 32'h100 || dmem_bus.dmem_be !== 4'hF) begin
            errors++; $display("FAIL load_req: req=%b we=%b addr=%h be=%h required 1 0 00000100 f",
                dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be);
        end
        dmem_bus.dmem_gnt = 1;
        tick(); dmem_bus.dmem_gnt = 0;
        if (lsu_busy) busy_cnt++;
        checks++;
        if (dmem_bus.dmem_req !== 0 || ld_wb_en !== 0) begin
            errors++; $display("FAIL load_wait: req=%b wb=%b required 0 0", dmem_bus.dmem_req, ld_wb_en);
        end
        dmem_bus.dmem_rvalid = 1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
        tick(); dmem_bus.dmem_rvalid = 0;
        if (lsu_busy) busy_cnt++;
        checks++;
        if (ld_wb_en !== 1 || ld_data !== 32'hDEADBEEF || ld_rd_o !== 5'd5 || lsu_err !== 0) begin
            errors++; $display("FAIL load_wb: wb=%b data=%h rd=%0d err=%b required 1 deadbeef 5 0",
                ld_wb_en, ld_data, ld_rd_o, lsu_err);
        end
        tick();
        checks++;
        if (ld_wb_en !== 0) begin
            errors++; $display("FAIL load_wb_pulse: wb=%b required 0", ld_wb_en);
        end
        checks++;
        if (busy_cnt != 2) begin
            errors++; $display("FAIL load_busy_cycles: got %0d required 2", busy_cnt);
        end
        $display("test_load addr=00000100 rd=5 data=%h", ld_data);
    endtask

    task automatic test_store_delayed_gnt();
        int bad = 0;
        addr = 32'h204; st_data = 32'h12345678; sd_valid = 1;
        tick(); sd_valid = 0;
        for (int i = 0; i < 5; i++) begin
            if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr, dmem_bus.dmem_wdata}
                    !== {1'b1, 1'b1, 4'hF, 32'h204, 32'h12345678} || ld_wb_en !== 0)
                bad++;
            if (i == 4) dmem_bus.dmem_gnt = 1;
            tick();
        end
        dmem_bus.dmem_gnt = 0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL store_stable: %0d unstable cycles required 0", bad);
        end
        checks++;
        if (lsu_busy !== 0 || dmem_bus.dmem_req !== 0 || ld_wb_en !== 0) begin
            errors++; $display("FAIL store_done: busy=%b req=%b wb=%b required 0 0 0",
                lsu_busy, dmem_bus.dmem_req, ld_wb_en);
        end
        $display("test_store addr=00000204 data=12345678");
    endtask

    task automatic test_reject();
        addr = 32'h102; ld_rd = 5'd1; ld_valid = 1;
        tick(); ld_valid = 0;
        checks++;
        if (dmem_bus.dmem_req !== 0 || lsu_busy !== 0 || lsu_err !== 1) begin
            errors++; $display("FAIL misaligned: req=%b busy=%b err=%b required 0 0 1",
                dmem_bus.dmem_req, lsu_busy, lsu_err);
        end
        tick();
        checks++;
        if (lsu_err !== 0 || dmem_bus.dmem_req !== 0) begin
            errors++; $display("FAIL misaligned_pulse: err=%b req=%b required 0 0", lsu_err, dmem_bus.dmem_req);
        end
        addr = 32'h100; ld_valid = 1; sd_valid = 1;
        tick(); ld_valid = 0; sd_valid = 0;
        checks++;
        if (dmem_bus.dmem_req !== 0 || lsu_busy !== 0 || lsu_err !== 1) begin
            errors++; $display("FAIL both_valid: req=%b busy=%b err=%b required 0 0 1",
                dmem_bus.dmem_req, lsu_busy, lsu_err);
        end
        tick();
        $display("test_reject misaligned and dual-valid");
    endtask

    task automatic test_back_to_back();
        addr = 32'h140; ld_rd = 5'd0; ld_valid = 1;
        tick(); ld_valid = 0; dmem_bus.dmem_gnt = 1;
        tick(); dmem_bus.dmem_gnt = 0; dmem_bus.dmem_rvalid = 1; dmem_bus.dmem_rdata = 32'h0BADF00D;
        tick(); dmem_bus.dmem_rvalid = 0;
        checks++;
        if (ld_wb_en !== 1 || ld_rd_o !== 5'd0 || ld_data !== 32'h0BADF00D || lsu_busy !== 0) begin
            errors++; $display("FAIL x0_load_wb: wb=%b rd=%0d data=%h busy=%b required 1 0 0badf00d 0",
                ld_wb_en, ld_rd_o, ld_data, lsu_busy);
        end
        addr = 32'h400; st_data = 32'hA5A5A5A5; sd_valid = 1;
        tick(); sd_valid = 0;
        checks++;
        if (dmem_bus.dmem_req !== 1 || dmem_bus.dmem_we !== 1 || dmem_bus.dmem_addr !== 32'h400 || dmem_bus.dmem_wdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL b2b_store: req=%b we=%b addr=%h wdata=%h required 1 1 00000400 a5a5a5a5",
                dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
        end
        dmem_bus.dmem_gnt = 1;
        tick(); dmem_bus.dmem_gnt = 0;
        checks++;
        if (lsu_busy !== 0 || dmem_bus.dmem_req !== 0) begin
            errors++; $display("FAIL b2b_done: busy=%b req=%b required 0 0", lsu_busy, dmem_bus.dmem_req);
        end
        $display("test_back_to_back load rd=0 then store 00000400");
    endtask

    task automatic test_timeout();
        int bad = 0;
        addr = 32'h300; ld_rd = 5'd3; ld_valid = 1;
        tick(); ld_valid = 0; dmem_bus.dmem_gnt = 1;
        tick(); dmem_bus.dmem_gnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (lsu_busy !== 1 || lsu_err !== 0 || ld_wb_en !== 0) bad++;
            if (k < 8) tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_wait: %0d bad WAIT_R cycles required 0", bad);
        end
        tick();
        checks++;
        if (lsu_err !== 1 || lsu_busy !== 0 || ld_wb_en !== 0 || dmem_bus.dmem_req !== 0) begin
            errors++; $display("FAIL timeout_abort: err=%b busy=%b wb=%b req=%b required 1 0 0 0",
                lsu_err, lsu_busy, ld_wb_en, dmem_bus.dmem_req);
        end
        tick();
        checks++;
        if (lsu_err !== 0 || ld_data !== 32'h0BADF00D || ld_rd_o !== 5'd0) begin
            errors++; $display("FAIL timeout_hold: err=%b data=%h rd=%0d required 0 0badf00d 0",
                lsu_err, ld_data, ld_rd_o);
        end
        $display("test_timeout after 8 WAIT_R cycles");
    endtask

    task automatic test_violation();
        addr = 32'h500; ld_rd = 5'd7; ld_valid = 1;
        tick(); ld_valid = 0;
        addr = 32'h800; st_data = 32'h0000FFFF; sd_valid = 1;
        tick(); sd_valid = 0;
        checks++;
        if (lsu_err !== 1 || dmem_bus.dmem_req !== 1 || dmem_bus.dmem_we !== 0 || dmem_bus.dmem_addr !== 32'h500) begin
            errors++; $display("FAIL viol_err: err=%b req=%b we=%b addr=%h required 1 1 0 00000500",
                lsu_err, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr);
        end
        dmem_bus.dmem_gnt = 1;
        tick(); dmem_bus.dmem_gnt = 0;
        checks++;
        if (lsu_err !== 0 || dmem_bus.dmem_req !== 0 || lsu_busy !== 1) begin
            errors++; $display("FAIL viol_wait: err=%b req=%b busy=%b required 0 0 1",
                lsu_err, dmem_bus.dmem_req, lsu_busy);
        end
        dmem_bus.dmem_rvalid = 1; dmem_bus.dmem_rdata = 32'hCAFEF00D;
        tick(); dmem_bus.dmem_rvalid = 0;
        checks++;
        if (ld_wb_en !== 1 || ld_data !== 32'hCAFEF00D || ld_rd_o !== 5'd7 || lsu_err !== 0) begin
            errors++; $display("FAIL viol_wb: wb=%b data=%h rd=%0d err=%b required 1 cafef00d 7 0",
                ld_wb_en, ld_data, ld_rd_o, lsu_err);
        end
        tick();
        checks++;
        if (dmem_bus.dmem_req !== 0 || lsu_busy !== 0 || lsu_err !== 0 || ld_wb_en !== 0) begin
            errors++; $display("FAIL viol_after: req=%b busy=%b err=%b wb=%b required 0 0 0 0",
                dmem_bus.dmem_req, lsu_busy, lsu_err, ld_wb_en);
        end
        $display("test_violation load 00000500 rd=7 completed");
    endtask

    task automatic test_reset_mid();
        addr = 32'h600; ld_rd = 5'd9; ld_valid = 1;
        tick(); ld_valid = 0; dmem_bus.dmem_gnt = 1;
        tick(); dmem_bus.dmem_gnt = 0;
        checks++;
        if (lsu_busy !== 1) begin
            errors++; $display("FAIL rstmid_busy: busy=%b required 1", lsu_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, lsu_busy, ld_wb_en, lsu_err, dmem_bus.dmem_be} !== 9'b0 ||
            ld_data !== 32'h0 || ld_rd_o !== 5'h0 || dmem_bus.dmem_addr !== 32'h0) begin
            errors++; $display("FAIL rstmid_async: req=%b busy=%b data=%h rd=%0d addr=%h required all 0",
                dmem_bus.dmem_req, lsu_busy, ld_data, ld_rd_o, dmem_bus.dmem_addr);
        end
        dmem_bus.dmem_rvalid = 1; dmem_bus.dmem_rdata = 32'h11111111;
        tick(); rst_n = 1'b1;
        tick(); dmem_bus.dmem_rvalid = 0;
        checks++;
        if (ld_wb_en !== 0 || ld_data !== 32'h0 || lsu_busy !== 0) begin
            errors++; $display("FAIL rstmid_rvalid: wb=%b data=%h busy=%b required 0 0 0",
                ld_wb_en, ld_data, lsu_busy);
        end
        tick();
        checks++;
        if (ld_wb_en !== 0 || lsu_err !== 0) begin
            errors++; $display("FAIL rstmid_quiet: wb=%b err=%b required 0 0", ld_wb_en, lsu_err);
        end
        $display("test_reset_mid access aborted");
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_delayed_gnt();
        test_reject();
        test_back_to_back();
        test_timeout();
        test_violation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
